// File: rtl/pool2d_engine.sv
// pool2d_engine: multi-channel square 2-D pooling (average or max) over a
// single-port word memory. Reads a channel-major N x N map from in_base and
// writes the pooled H x H map per channel to out_base.
// Ports: clk/rst (async active-high); start/mode/pool_size/stride/dim/channels/
// in_base/out_base configure one run; mem_rd_* / mem_wr_* form the memory port
// (read data returns one cycle after mem_rd_en); busy/done/err report status.
module pool2d_engine #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int DIM_WIDTH  = 4,
  parameter int CH_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [DIM_WIDTH-1:0]  pool_size,
  input  logic [DIM_WIDTH-1:0]  stride,
  input  logic [DIM_WIDTH-1:0]  dim,
  input  logic [CH_WIDTH-1:0]   channels,
  input  logic [ADDR_WIDTH-1:0] in_base,
  input  logic [ADDR_WIDTH-1:0] out_base,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int ACC_W = DATA_WIDTH + 2 * DIM_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_ACC,
    S_WR,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Latched run configuration
  logic                  mode_q;
  logic [DIM_WIDTH-1:0]  p_q, s_q, n_q, h_q;
  logic [CH_WIDTH-1:0]   ch_num_q;
  logic [ADDR_WIDTH-1:0] in_base_q, out_base_q;
  logic                  err_q;

  // Traversal counters
  logic [CH_WIDTH-1:0]   ch_q;
  logic [DIM_WIDTH-1:0]  orow_q, ocol_q, wrow_q, wcol_q;

  logic signed [ACC_W-1:0] acc_q;

  // Address/data hold registers so the memory outputs keep their last value
  logic [ADDR_WIDTH-1:0] rd_addr_hold_q, wr_addr_hold_q;
  logic [DATA_WIDTH-1:0] wr_data_hold_q;

  // Start-time configuration checks and output side
  logic                 illegal_cfg;
  logic [DIM_WIDTH-1:0] stride_safe;
  logic [DIM_WIDTH-1:0] h_new;

  assign illegal_cfg = (pool_size == '0) || (stride == '0) ||
                       (channels == '0) || (pool_size > dim);
  // stride_safe only avoids a divide by zero; an illegal config never runs
  assign stride_safe = (stride == '0) ? DIM_WIDTH'(1) : stride;
  assign h_new       = ((dim - pool_size) / stride_safe) + DIM_WIDTH'(1);

  // Element and result addresses; all arithmetic wraps at ADDR_WIDTH
  logic [DIM_WIDTH-1:0]  in_row, in_col;
  logic [ADDR_WIDTH-1:0] rd_addr_c, wr_addr_c;

  assign in_row = (orow_q * s_q) + wrow_q;
  assign in_col = (ocol_q * s_q) + wcol_q;

  assign rd_addr_c = in_base_q
                   + ADDR_WIDTH'(ch_q) * ADDR_WIDTH'(n_q) * ADDR_WIDTH'(n_q)
                   + ADDR_WIDTH'(in_row) * ADDR_WIDTH'(n_q)
                   + ADDR_WIDTH'(in_col);

  assign wr_addr_c = out_base_q
                   + ADDR_WIDTH'(ch_q) * ADDR_WIDTH'(h_q) * ADDR_WIDTH'(h_q)
                   + ADDR_WIDTH'(orow_q) * ADDR_WIDTH'(h_q)
                   + ADDR_WIDTH'(ocol_q);

  // Loop-end flags
  logic last_elem, last_col, last_row, last_ch, first_elem;

  assign first_elem = (wrow_q == '0) && (wcol_q == '0);
  assign last_elem  = (wrow_q == p_q - DIM_WIDTH'(1)) && (wcol_q == p_q - DIM_WIDTH'(1));
  assign last_col   = (ocol_q == h_q - DIM_WIDTH'(1));
  assign last_row   = (orow_q == h_q - DIM_WIDTH'(1));
  assign last_ch    = (ch_q == ch_num_q - CH_WIDTH'(1));

  // Datapath: sign-extended read data and window result
  logic signed [ACC_W-1:0] rd_ext;
  logic signed [ACC_W-1:0] area_s;
  logic [DATA_WIDTH-1:0]   result_c;

  assign rd_ext = {{(2 * DIM_WIDTH){mem_rd_data[DATA_WIDTH-1]}}, mem_rd_data};
  // Divisor forced to 1 outside a run so the divider never sees zero
  assign area_s = (p_q == '0) ? ACC_W'(1) : ACC_W'(p_q) * ACC_W'(p_q);
  // Signed division truncates toward zero
  assign result_c = mode_q ? acc_q[DATA_WIDTH-1:0]
                           : DATA_WIDTH'(acc_q / area_s);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and strobes
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = illegal_cfg ? S_DONE : S_RD;
        end
      end
      S_RD: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        state_d   = S_ACC;
      end
      S_ACC: begin
        busy    = 1'b1;
        state_d = last_elem ? S_WR : S_RD;
      end
      S_WR: begin
        busy      = 1'b1;
        mem_wr_en = 1'b1;
        state_d   = (last_col && last_row && last_ch) ? S_DONE : S_RD;
      end
      S_DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Addresses are driven live during their strobe, held otherwise
  assign mem_rd_addr = (state_q == S_RD) ? rd_addr_c : rd_addr_hold_q;
  assign mem_wr_addr = (state_q == S_WR) ? wr_addr_c : wr_addr_hold_q;
  assign mem_wr_data = (state_q == S_WR) ? result_c  : wr_data_hold_q;

  // Configuration, counters, accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q         <= 1'b0;
      p_q            <= '0;
      s_q            <= '0;
      n_q            <= '0;
      h_q            <= '0;
      ch_num_q       <= '0;
      in_base_q      <= '0;
      out_base_q     <= '0;
      err_q          <= 1'b0;
      ch_q           <= '0;
      orow_q         <= '0;
      ocol_q         <= '0;
      wrow_q         <= '0;
      wcol_q         <= '0;
      acc_q          <= '0;
      rd_addr_hold_q <= '0;
      wr_addr_hold_q <= '0;
      wr_data_hold_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q     <= mode;
            p_q        <= pool_size;
            s_q        <= stride;
            n_q        <= dim;
            h_q        <= h_new;
            ch_num_q   <= channels;
            in_base_q  <= in_base;
            out_base_q <= out_base;
            err_q      <= illegal_cfg;
            ch_q       <= '0;
            orow_q     <= '0;
            ocol_q     <= '0;
            wrow_q     <= '0;
            wcol_q     <= '0;
            acc_q      <= '0;
          end
        end
        S_RD: begin
          rd_addr_hold_q <= rd_addr_c;
        end
        S_ACC: begin
          if (mode_q) begin
            // First element seeds the max; later ones replace if larger
            if (first_elem || (rd_ext > acc_q)) begin
              acc_q <= rd_ext;
            end
          end else begin
            acc_q <= acc_q + rd_ext;
          end
          // Window counters hold on the last element so WR sees them intact
          if (!last_elem) begin
            if (wcol_q == p_q - DIM_WIDTH'(1)) begin
              wcol_q <= '0;
              wrow_q <= wrow_q + DIM_WIDTH'(1);
            end else begin
              wcol_q <= wcol_q + DIM_WIDTH'(1);
            end
          end
        end
        S_WR: begin
          wr_addr_hold_q <= wr_addr_c;
          wr_data_hold_q <= result_c;
          acc_q          <= '0;
          wrow_q         <= '0;
          wcol_q         <= '0;
          if (last_col) begin
            ocol_q <= '0;
            if (last_row) begin
              orow_q <= '0;
              ch_q   <= ch_q + CH_WIDTH'(1);
            end else begin
              orow_q <= orow_q + DIM_WIDTH'(1);
            end
          end else begin
            ocol_q <= ocol_q + DIM_WIDTH'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pool2d_engine.sv
// Testbench for pool2d_engine: directed scenarios plus randomized runs checked
// against a plain-arithmetic pooling model over a behavioural memory.
module tb_pool2d_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic [3:0]  pool_size, stride, dim;
  logic [2:0]  channels;
  logic [11:0] in_base, out_base;
  logic        mem_rd_en, mem_wr_en;
  logic [11:0] mem_rd_addr, mem_wr_addr;
  logic [31:0] mem_rd_data;
  logic [31:0] mem_wr_data;
  logic        busy, done, err;

  int tests  = 0;
  int failed = 0;

  logic [31:0] mem [0:4095];

  logic [11:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [11:0] ra_q[$];

  logic [11:0] exp_wa[$];
  logic [31:0] exp_wd[$];
  logic [11:0] exp_ra[$];
  int          exp_busy;

  always #5 clk = ~clk;

  pool2d_engine dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .pool_size  (pool_size),
    .stride     (stride),
    .dim        (dim),
    .channels   (channels),
    .in_base    (in_base),
    .out_base   (out_base),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Synchronous read memory: data one cycle after the strobe
  initial mem_rd_data = '0;
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  // Transaction logger, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_wr_en) begin
      wa_q.push_back(mem_wr_addr);
      wd_q.push_back(mem_wr_data);
    end
    if (mem_rd_en) ra_q.push_back(mem_rd_addr);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model: straightforward nested loops over the window definition
  task automatic build_model(input bit md, input int p, s, n, c, inb, outb);
    int h;
    longint sum;
    int v, mx, addr;
    logic [31:0] res;
    exp_wa.delete(); exp_wd.delete(); exp_ra.delete();
    h = (n - p) / s + 1;
    for (int ch = 0; ch < c; ch++)
      for (int orow = 0; orow < h; orow++)
        for (int ocol = 0; ocol < h; ocol++) begin
          sum = 0;
          mx  = 0;
          for (int wr = 0; wr < p; wr++)
            for (int wc = 0; wc < p; wc++) begin
              addr = (inb + ch*n*n + (orow*s + wr)*n + ocol*s + wc) % 4096;
              exp_ra.push_back(12'(addr));
              v = $signed(mem[addr]);
              sum += v;
              if ((wr == 0 && wc == 0) || v > mx) mx = v;
            end
          res = md ? 32'(mx) : 32'(sum / longint'(p*p));
          exp_wd.push_back(res);
          exp_wa.push_back(12'((outb + ch*h*h + orow*h + ocol) % 4096));
        end
    exp_busy = c * h * h * (2*p*p + 1);
  endtask

  task automatic clear_logs();
    wa_q.delete(); wd_q.delete(); ra_q.delete();
  endtask

  task automatic check_idle_zero(input string tag);
    chk(tag, {busy, done, err, mem_rd_en, mem_wr_en, mem_rd_addr, mem_wr_addr, mem_wr_data}, 64'd0);
  endtask

  // Full legal run; optional disturbing start while busy
  task automatic run_job(input bit md, input int p, s, n, c, inb, outb, input bit disturb);
    int  cnt;
    bit  seen;
    int  nw, nr;
    build_model(md, p, s, n, c, inb, outb);
    clear_logs();
    @(negedge clk);
    mode = md; pool_size = 4'(p); stride = 4'(s); dim = 4'(n);
    channels = 3'(c); in_base = 12'(inb); out_base = 12'(outb);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0; seen = 0;
    for (int i = 0; i < 30000; i++) begin
      if (done) begin seen = 1; break; end
      if (busy) cnt++;
      if (disturb && i == 3) begin
        start = 1'b1; mode = ~md; pool_size = 4'd1; stride = 4'd1; out_base = 12'h7F0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", 64'(seen), 64'd1);
    chk("busy_cycles", 64'(cnt), 64'(exp_busy));
    chk("err_on_legal", 64'(err), 64'd0);
    chk("busy_at_done", 64'(busy), 64'd0);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("n_writes", 64'(wa_q.size()), 64'(exp_wa.size()));
    chk("n_reads", 64'(ra_q.size()), 64'(exp_ra.size()));
    nw = (wa_q.size() < exp_wa.size()) ? wa_q.size() : exp_wa.size();
    nr = (ra_q.size() < exp_ra.size()) ? ra_q.size() : exp_ra.size();
    for (int k = 0; k < nw; k++) begin
      chk("wr_addr", 64'(wa_q[k]), 64'(exp_wa[k]));
      chk("wr_data", 64'(wd_q[k]), 64'(exp_wd[k]));
    end
    for (int k = 0; k < nr; k++) chk("rd_addr", 64'(ra_q[k]), 64'(exp_ra[k]));
  endtask

  task automatic illegal_run(input int p, s, n, c);
    clear_logs();
    @(negedge clk);
    mode = 1'b0; pool_size = 4'(p); stride = 4'(s); dim = 4'(n); channels = 3'(c);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("illegal_done", 64'(done), 64'd1);
    chk("illegal_err", 64'(err), 64'd1);
    chk("illegal_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("illegal_pulse_end", {62'd0, done, err}, 64'd0);
    repeat (3) @(negedge clk);
    chk("illegal_no_mem", 64'(ra_q.size() + wa_q.size()), 64'd0);
  endtask

  task automatic t1_data();
    for (int i = 0; i < 16; i++) mem[12'h010 + i] = 32'(i + 1);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] k1 [4];
    bit found;
    int n, p, s, c, inb, outb;
    bit md;

    rst = 1'b1; start = 1'b0; mode = 1'b0; pool_size = '0; stride = '0;
    dim = '0; channels = '0; in_base = '0; out_base = '0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    #12;
    check_idle_zero("reset_outputs");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("idle_after_reset");

    // Average, sequential data
    t1_data();
    run_job(1'b0, 2, 2, 4, 1, 12'h010, 12'h200, 1'b0);
    k1 = '{32'd3, 32'd5, 32'd11, 32'd13};
    for (int k = 0; k < 4; k++) begin
      got = (k < wd_q.size()) ? wd_q[k] : 32'hxxxxxxxx;
      chk("avg_known", 64'(got), 64'(k1[k]));
    end

    // Max, same data, with a start issued mid-run that must be ignored
    run_job(1'b1, 2, 2, 4, 1, 12'h010, 12'h200, 1'b1);
    k1 = '{32'd6, 32'd8, 32'd14, 32'd16};
    for (int k = 0; k < 4; k++) begin
      got = (k < wd_q.size()) ? wd_q[k] : 32'hxxxxxxxx;
      chk("max_known", 64'(got), 64'(k1[k]));
    end

    // Negative averages truncate toward zero
    for (int i = 0; i < 16; i++) mem[12'h300 + i] = $urandom;
    mem[12'h300] = -32'sd1; mem[12'h301] = -32'sd2; mem[12'h304] = -32'sd3; mem[12'h305] = -32'sd4;
    mem[12'h302] = -32'sd1; mem[12'h303] = 32'd0;  mem[12'h306] = 32'd0;   mem[12'h307] = 32'd0;
    run_job(1'b0, 2, 2, 4, 1, 12'h300, 12'h340, 1'b0);
    got = (wd_q.size() > 0) ? wd_q[0] : 32'hxxxxxxxx;
    chk("avg_neg_m2", 64'(got), 64'hFFFF_FFFE);
    got = (wd_q.size() > 1) ? wd_q[1] : 32'hxxxxxxxx;
    chk("avg_neg_zero", 64'(got), 64'd0);

    // Address wrap, two channels, stride 1
    for (int i = 0; i < 18; i++) mem[(12'hFFC + i) % 4096] = $urandom;
    run_job(1'b0, 2, 1, 3, 2, 12'hFFC, 12'h400, 1'b0);
    found = 0;
    foreach (ra_q[k]) if (ra_q[k] == 12'h000) found = 1;
    chk("wrap_read_0", 64'(found), 64'd1);

    // Illegal configurations, then a legal run still works
    illegal_run(5, 1, 4, 1);
    illegal_run(2, 0, 4, 1);
    illegal_run(2, 2, 4, 0);
    illegal_run(0, 1, 4, 1);
    run_job(1'b1, 2, 2, 4, 1, 12'h010, 12'h200, 1'b0);

    // Reset during ACC of the second window
    clear_logs();
    @(negedge clk);
    mode = 1'b0; pool_size = 4'd2; stride = 4'd2; dim = 4'd4; channels = 3'd1;
    in_base = 12'h010; out_base = 12'h200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (wa_q.size() == 1 && mem_rd_en) begin found = 1; break; end
      @(negedge clk);
    end
    chk("reached_win2_rd", 64'(found), 64'd1);
    @(negedge clk);
    chk("in_acc_busy", 64'(busy), 64'd1);
    #1 rst = 1'b1;
    #1 check_idle_zero("reset_mid_run");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_write_after_rst", 64'(wa_q.size()), 64'd1);
    check_idle_zero("idle_after_abort");
    run_job(1'b0, 2, 2, 4, 1, 12'h010, 12'h200, 1'b0);

    // Randomized legal runs
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 6);
      p = $urandom_range(1, n);
      s = $urandom_range(1, 3);
      c = $urandom_range(1, 3);
      md = 1'($urandom_range(0, 1));
      inb = $urandom_range(0, 4095);
      outb = $urandom_range(0, 4095);
      for (int i = 0; i < c*n*n; i++) mem[(inb + i) % 4096] = $urandom;
      run_job(md, p, s, n, c, inb, outb, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
